// File: rtl/seq_detector_param_if.sv
// Serial bit stream, pattern load and status bundle for seq_detector_param.
interface seq_detector_param_if #(
  parameter int N     = 5,
  parameter int CNT_W = 8
);
  logic             en;
  logic             j;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic             cnt_clr;
  logic             w;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output en, j, pat_load, pat_in, cnt_clr,
                  input  w, match_cnt, cnt_sat);
  modport slave  (input  en, j, pat_load, pat_in, cnt_clr,
                  output w, match_cnt, cnt_sat);
endinterface

// File: rtl/seq_detector_param.sv
// N-bit serial pattern detector with runtime-loadable pattern, overlap mode,
// bit-valid qualifier and saturating match counter. Match pulse is registered.
module seq_detector_param #(
  parameter int             N       = 5,
  parameter logic [N-1:0]   PATTERN = 5'b10010,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_detector_param_if.slave bus
);
  localparam int             FW       = $clog2(N + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(N);
  localparam logic [FW-1:0]  FILL_NM1 = FW'(N - 1);

  logic [N-1:0]     pat, hist, nh;
  logic [FW-1:0]    fill, fill_inc;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             w_q, sat_q, match_now;

  assign nh       = {hist[N-2:0], bus.j};
  // fill counts bits already held; the incoming bit completes N when fill is N-1
  assign match_now = bus.en & ~bus.pat_load & (fill >= FILL_NM1) & (nh == pat);
  assign fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
  assign cnt_inc  = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat   <= PATTERN;
      hist  <= '0;
      fill  <= '0;
      w_q   <= 1'b0;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else begin
      w_q <= match_now;
      if (bus.pat_load) begin
        pat  <= bus.pat_in;
        hist <= '0;
        fill <= '0;
      end else if (bus.en) begin
        hist <= nh;
        fill <= (!OVERLAP && match_now) ? '0 : fill_inc;
      end
      if (bus.cnt_clr) begin
        cnt   <= '0;
        sat_q <= 1'b0;
      end else if (match_now && !(&cnt)) begin
        cnt   <= cnt_inc;
        sat_q <= &cnt_inc;
      end
    end
  end

  assign bus.w         = w_q;
  assign bus.match_cnt = cnt;
  assign bus.cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: three detector builds (overlap, non-overlap, 2-bit counter)
// share one stimulus stream; each phase checks the build it targets.
module tb_seq_detector_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, j = 1'b0, pat_load = 1'b0, cnt_clr = 1'b0;
  logic [4:0] pat_in = 5'b0;
  int         nchecks = 0;
  int         nerrors = 0;

  always #5 clk = ~clk;

  seq_detector_param_if #(.N(5), .CNT_W(8)) b1 ();
  seq_detector_param_if #(.N(5), .CNT_W(8)) b0 ();
  seq_detector_param_if #(.N(5), .CNT_W(2)) b2 ();

  assign b1.en = en;  assign b1.j = j;  assign b1.pat_load = pat_load;
  assign b1.pat_in = pat_in;  assign b1.cnt_clr = cnt_clr;
  assign b0.en = en;  assign b0.j = j;  assign b0.pat_load = pat_load;
  assign b0.pat_in = pat_in;  assign b0.cnt_clr = cnt_clr;
  assign b2.en = en;  assign b2.j = j;  assign b2.pat_load = pat_load;
  assign b2.pat_in = pat_in;  assign b2.cnt_clr = cnt_clr;

  seq_detector_param #(.N(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .CNT_W(8))
    u_ov (.clk(clk), .rst(rst), .bus(b1));
  seq_detector_param #(.N(5), .PATTERN(5'b10010), .OVERLAP(1'b0), .CNT_W(8))
    u_nov (.clk(clk), .rst(rst), .bus(b0));
  seq_detector_param #(.N(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .CNT_W(2))
    u_sat (.clk(clk), .rst(rst), .bus(b2));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic b, input logic pl, input logic cc);
    en = e; j = b; pat_load = pl; cnt_clr = cc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic wsel(input int sel);
    case (sel)
      0:       return b0.w;
      1:       return b1.w;
      default: return b2.w;
    endcase
  endfunction

  // bits/wexp are written first-bit-first in the MSBs of an n-bit field
  task automatic stream(input int sel, input logic [31:0] bits, input logic [31:0] wexp,
                        input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], 1'b0, 1'b0);
      check($sformatf("%s_w%0d", tag, i + 1), {7'b0, wsel(sel)}, {7'b0, wexp[n-1-i]});
    end
    en = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; j = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_w",   {7'b0, b1.w}, 8'd0);
    check("rst_cnt", b1.match_cnt, 8'd0);
    check("rst_sat", {7'b0, b1.cnt_sat}, 8'd0);

    // overlapping: matches end at bits 5 and 8
    stream(1, 32'b10010010, 32'b00001001, 8, "ov");
    check("ov_cnt", b1.match_cnt, 8'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ov_idle_w", {7'b0, b1.w}, 8'd0);

    // non-overlapping: bits 6-8 cannot reuse the first match
    do_reset();
    stream(0, 32'b100100101010010, 32'b000010000000001, 15, "nov");
    check("nov_cnt", b0.match_cnt, 8'd2);

    // en gap between bits 3 and 4
    do_reset();
    stream(1, 32'b100, 32'b000, 3, "gap_a");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("gap_idle%0d", i), {7'b0, b1.w}, 8'd0);
    end
    stream(1, 32'b10, 32'b01, 2, "gap_b");
    check("gap_cnt", b1.match_cnt, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_after_w", {7'b0, b1.w}, 8'd0);

    // all-zero pattern: still needs 5 accepted bits; load drops its own bit
    do_reset();
    pat_in = 5'b00000;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ld_w", {7'b0, b1.w}, 8'd0);
    stream(1, 32'b0, 32'b0000111, 7, "z");
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("ld_en_w", {7'b0, b1.w}, 8'd0);
    stream(1, 32'b0, 32'b00001, 5, "z2");
    check("z_cnt", b1.match_cnt, 8'd4);

    // saturating 2-bit counter, default pattern restored by reset
    do_reset();
    stream(2, 32'b10010010, 32'b00001001, 8, "sat_a");
    check("sat_a_cnt", {6'b0, b2.match_cnt}, 8'd2);
    check("sat_a_sat", {7'b0, b2.cnt_sat}, 8'd0);
    stream(2, 32'b010, 32'b001, 3, "sat_b");
    check("sat_b_cnt", {6'b0, b2.match_cnt}, 8'd3);
    check("sat_b_sat", {7'b0, b2.cnt_sat}, 8'd1);
    stream(2, 32'b010010, 32'b001001, 6, "sat_c");
    check("sat_c_cnt", {6'b0, b2.match_cnt}, 8'd3);
    check("sat_c_sat", {7'b0, b2.cnt_sat}, 8'd1);
    stream(2, 32'b01, 32'b00, 2, "sat_d");
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_w",   {7'b0, b2.w}, 8'd1);
    check("clr_cnt", {6'b0, b2.match_cnt}, 8'd0);
    check("clr_sat", {7'b0, b2.cnt_sat}, 8'd0);
    stream(2, 32'b010, 32'b001, 3, "sat_e");
    check("sat_e_cnt", {6'b0, b2.match_cnt}, 8'd1);

    // asynchronous reset mid-stream
    do_reset();
    stream(1, 32'b1001001, 32'b0000100, 7, "ar");
    check("ar_pre_cnt", b1.match_cnt, 8'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_w",   {7'b0, b1.w}, 8'd0);
    check("ar_cnt", b1.match_cnt, 8'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    stream(1, 32'b0, 32'b0, 1, "ar_tail");
    stream(1, 32'b10010, 32'b00001, 5, "ar_full");
    check("ar_full_cnt", b1.match_cnt, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
